// File: rtl/rr_arbiter_8_pkg.sv
// Shared types, constants and rotation helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Rotate right by sh: the bit at position sh lands at position 0.
    function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input logic [IDXW-1:0] sh);
        logic [2*N-1:0] dbl;
        dbl  = {x, x} >> sh;
        rotr = dbl[N-1:0];
    endfunction

    // Rotate left by sh: undoes rotr with the same shift amount.
    function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input logic [IDXW-1:0] sh);
        logic [2*N-1:0] dbl;
        dbl  = {x, x} << sh;
        rotl = dbl[2*N-1:N];
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_v;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_v, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_v, timeout
    );
endinterface

// File: rtl/rr_arbiter_8_onehot_enc8.sv
// Combinational 8-to-3 one-hot to binary encoder with a valid flag.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    // Each index bit is the OR of every input position whose index has that bit set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < IDXW; gi++) begin : g_bit
            logic [N-1:0] sel;
            for (gj = 0; gj < N; gj++) begin : g_pos
                if (((gj >> gi) & 1) == 1) begin : g_on
                    assign sel[gj] = onehot[gj];
                end else begin : g_off
                    assign sel[gj] = 1'b0;
                end
            end
            assign idx[gi] = |sel;
        end
    endgenerate

    assign valid = |onehot;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a per-grant hold limit.
// One idle bubble follows every release before the next grant is decided.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_8_if.slave bus
);

    arb_state_t      state_reg;
    logic [IDXW-1:0] ptr_reg;
    logic [CNTW-1:0] hold_cnt_reg;
    logic [N-1:0]    gnt_reg;
    logic [IDXW-1:0] gnt_idx_reg;
    logic            gnt_v_reg;
    logic            timeout_reg;

    logic [N-1:0]    rot_req;
    logic [N-1:0]    rot_pick;
    logic [N-1:0]    win_onehot;
    logic [IDXW-1:0] win_idx;
    logic            win_valid;

    logic            owner_done;
    logic            owner_req;
    logic            expired;
    logic            release_now;

    // Search starts at ptr: rotate it down to bit 0, isolate the lowest set bit, rotate back.
    assign rot_req    = rotr(bus.req, ptr_reg);
    assign rot_pick   = rot_req & (~rot_req + N'(1));
    assign win_onehot = rotl(rot_pick, ptr_reg);

    onehot_enc8 u_enc (
        .onehot (win_onehot),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    assign owner_done  = bus.done[gnt_idx_reg];
    assign owner_req   = bus.req[gnt_idx_reg];
    assign expired     = (hold_cnt_reg == CNTW'(MAX_HOLD));
    assign release_now = owner_done || !owner_req || expired;

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            gnt_v_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg <= 1'b0;
                    if (win_valid) begin
                        gnt_reg      <= win_onehot;
                        gnt_idx_reg  <= win_idx;
                        gnt_v_reg    <= 1'b1;
                        hold_cnt_reg <= CNTW'(1);
                        state_reg    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_reg      <= '0;
                        gnt_v_reg    <= 1'b0;
                        hold_cnt_reg <= '0;
                        ptr_reg      <= gnt_idx_reg + IDXW'(1);
                        // A voluntary release (done or dropped req) masks expiry.
                        timeout_reg  <= !owner_done && owner_req;
                        state_reg    <= RELEASE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + CNTW'(1);
                    end
                end
                RELEASE: begin
                    timeout_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.gnt_idx = gnt_idx_reg;
    assign bus.gnt_v   = gnt_v_reg;
    assign bus.timeout = timeout_reg;

endmodule
